jal_issue_buffer: RTL
=====================

// Module: jal_issue_buffer
// PURPOSE
//  Reservation buffer between dispatch and the JAL/JALR issue stage. Holds up to DP
//  jump micro-ops written by dispatch; issue reads every entry in parallel and retires
//  one entry per cycle by index. Out-of-order pop, lowest-free-slot allocation, and a
//  flush that empties the buffer on pipeline redirect.
// PARAMETERS
//  DW  `JAL_ISSUE_INFO_DW  width of one packed entry {jal,jalr,pc[63:0],rd0,rs1,is_rvc}
//  DP  `JAL_ISSUE_INFO_DP  entry count; power of two, >=2
// PORTS
//  CLK                   in   1            clock, rising edge
//  RST                   in   1            synchronous reset, active high
//  flush                 in   1            redirect: drop all entries
//  jal_dispat_push       in   1            dispatch writes one entry this cycle
//  jal_dispat_info       in   DW           entry payload for the push
//  jal_buffer_full       out  1            all DP entries allocated (registered state)
//  jal_buffer_pop        in   1            issue retires one entry this cycle
//  jal_buffer_pop_index  in   $clog2(DP)   index of the retired entry
//  jal_buffer_malloc     out  DP           per-entry valid, bit i = entry i
//  jal_issue_info        out  DW*DP        entry i at [DW*i +: DW]
//  jal_buffer_cnt        out  $clog2(DP)+1 number of valid entries
//  jal_buffer_err        out  1            sticky protocol-error flag
// BEHAVIOUR
//  - Reset (sync, RST=1 at edge): malloc=0, all info words=0, cnt=0, err=0, full=0.
//  - All outputs come straight from registers. No combinational path from any input
//    to any output.
//  - Allocation: the push goes to the lowest-index entry with malloc=0. The free-slot
//    search uses malloc as registered this cycle. Entries freed this cycle are NOT
//    reused until the next cycle.
//  - Push accepted iff push & ~full & ~flush. On acceptance: info[slot] <= dispat_info,
//    malloc[slot] <= 1 at the next edge. Visible to issue one cycle after the push.
//  - A push while full is dropped, info is unchanged, and err <= 1.
//  - Pop accepted iff pop & malloc[pop_index] & ~flush: malloc[pop_index] <= 0, and
//    info is left stale. A pop of an unallocated entry is ignored and sets err <= 1.
//  - Simultaneous push+pop: both take effect. The slots cannot collide, because the
//    push slot is free and the pop slot is allocated. Net cnt is unchanged.
//  - When full, push+pop in the same cycle: the pop frees its slot, the push is
//    dropped, and err <= 1. Dispatch must sample full, so this is a dispatch bug.
//  - flush: malloc <= 0 and cnt <= 0 next edge. Flush overrides push and pop and does
//    not set err. err clears only on RST.
//  - Precedence: RST > flush > {push, pop}.
//  - cnt and full are kept as registers consistent with malloc:
//    cnt_next = cnt + push_acc - pop_acc.
//    full_next = (cnt_next == DP).
//  - Reset or flush mid-burst: the in-flight push of that cycle is discarded, and the
//    entry written the cycle before is discarded too.
// STRUCTURE
//  - Entry widths and the DW/DP defaults are macros in the shared define.vh
//    (`JAL_ISSUE_INFO_DW, `JAL_ISSUE_INFO_DP, `RB). No new typedefs are needed.
//  - Sub-module: the existing lzp priority encoder, fed ~malloc, finds the lowest free
//    slot. all1 of ~malloc means empty. Do not duplicate it.
//  - Storage: DP x DW payload flops with write enable, DP valid flops, and the
//    cnt/full/err flops. Use synchronous-reset flop wrappers, not gen_dffr.
// TESTING (DP=4)
//  1. Reset, then push 4 entries with pc=0x1000,0x1004,0x1008,0x100C on consecutive
//     cycles -> malloc 0001,0011,0111,1111; full=1 and cnt=4 after the 4th; info[i]
//     matches.
//  2. Full, pop index 2 -> malloc=1011, full=0. Next push pc=0x2000 lands in entry 2,
//     malloc=1111.
//  3. malloc=0011, push and pop index 0 in the same cycle -> malloc=0110, cnt stays 2,
//     new payload in entry 2, not entry 0.
//  4. Full, push without pop -> dropped, info unchanged, err=1 and stays 1 through
//     later traffic until RST.
//  5. malloc=0101, flush together with push and pop index 0 -> malloc=0000, cnt=0,
//     full=0, err=0.
//  6. Pop of unallocated index 3 with malloc=0001 -> malloc unchanged, err=1. Then
//     RST=1 for one cycle -> all outputs return to 0.

Source files
------------

// File: rtl/jal_issue_buffer_pkg.sv
// -----------------------------------------------------------------------------
// jal_issue_buffer_pkg
// Shared constants for the JAL/JALR issue buffer.
// The packed entry layout, MSB to LSB, is:
//   {jal, jalr, pc[63:0], rd0[4:0], rs1[4:0], is_rvc}
// -----------------------------------------------------------------------------
package jal_issue_buffer_pkg;

    localparam int JAL_PC_W          = 64;
    localparam int JAL_REG_W         = 5;
    localparam int JAL_ISSUE_INFO_DW = 1 + 1 + JAL_PC_W + JAL_REG_W + JAL_REG_W + 1;
    localparam int JAL_ISSUE_INFO_DP = 4;

    // Builds one packed entry from its fields.
    function automatic logic [JAL_ISSUE_INFO_DW-1:0] jal_pack_info(
        input logic                 jal,
        input logic                 jalr,
        input logic [JAL_PC_W-1:0]  pc,
        input logic [JAL_REG_W-1:0] rd0,
        input logic [JAL_REG_W-1:0] rs1,
        input logic                 is_rvc
    );
        return {jal, jalr, pc, rd0, rs1, is_rvc};
    endfunction

endpackage

// File: rtl/jal_issue_buffer_lzp.sv
// -----------------------------------------------------------------------------
// jal_issue_buffer_lzp
// Lowest-set-bit priority encoder. The buffer feeds it the inverted valid
// vector, so the index it produces is the lowest free slot.
// Ports:
//   req  in  N          request vector, bit 0 has highest priority
//   idx  out $clog2(N)  index of the lowest set bit (0 when req is all zero)
// -----------------------------------------------------------------------------
module jal_issue_buffer_lzp #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    output logic [$clog2(N)-1:0] idx
);

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = ($clog2(N))'(i);
            end
        end
    end

endmodule

// File: rtl/jal_issue_buffer.sv
// -----------------------------------------------------------------------------
// jal_issue_buffer
// Reservation buffer between dispatch and the JAL/JALR issue stage. Dispatch
// writes one jump micro-op per cycle into the lowest free entry; issue sees
// every entry in parallel and retires one entry per cycle by index (out of
// order). A flush empties the buffer on a pipeline redirect.
//
// Handshake: dispatch may push only when jal_buffer_full is low (sampled the
// same cycle); a push while full is dropped and flagged. Issue may pop only an
// entry whose jal_buffer_malloc bit is set; any other pop is ignored and
// flagged. There is no backpressure beyond jal_buffer_full.
//
// Ports:
//   CLK, RST               clock (rising edge), synchronous active-high reset
//   flush                  drop every entry; overrides push and pop
//   jal_dispat_push/info   dispatch write strobe and payload
//   jal_buffer_full        all DP entries allocated
//   jal_buffer_pop/index   issue retire strobe and entry index
//   jal_buffer_malloc      per-entry valid, bit i = entry i
//   jal_issue_info         entry i at [DW*i +: DW]
//   jal_buffer_cnt         number of valid entries
//   jal_buffer_err         sticky protocol error, cleared only by RST
// All outputs are driven directly from flops.
// -----------------------------------------------------------------------------
module jal_issue_buffer
    import jal_issue_buffer_pkg::*;
#(
    parameter int DW = JAL_ISSUE_INFO_DW,
    parameter int DP = JAL_ISSUE_INFO_DP
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  flush,
    input  logic                  jal_dispat_push,
    input  logic [DW-1:0]         jal_dispat_info,
    output logic                  jal_buffer_full,
    input  logic                  jal_buffer_pop,
    input  logic [$clog2(DP)-1:0] jal_buffer_pop_index,
    output logic [DP-1:0]         jal_buffer_malloc,
    output logic [DW*DP-1:0]      jal_issue_info,
    output logic [$clog2(DP):0]   jal_buffer_cnt,
    output logic                  jal_buffer_err
);

    localparam int IW = $clog2(DP);
    localparam int CW = IW + 1;

    logic [DP-1:0] malloc_q, malloc_d;
    logic [DW-1:0] info_q [DP];
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          err_q, err_d;

    logic [IW-1:0] free_idx;
    logic          push_acc;
    logic          pop_acc;
    logic          push_bad;
    logic          pop_bad;

    // Searches the registered valid vector, so an entry popped this cycle
    // is not reused until the next one.
    jal_issue_buffer_lzp #(.N(DP)) u_lzp (
        .req (~malloc_q),
        .idx (free_idx)
    );

    assign push_acc = jal_dispat_push & ~full_q & ~flush;
    assign pop_acc  = jal_buffer_pop & malloc_q[jal_buffer_pop_index] & ~flush;
    assign push_bad = jal_dispat_push & full_q & ~flush;
    assign pop_bad  = jal_buffer_pop & ~malloc_q[jal_buffer_pop_index] & ~flush;

    // Push slot is free and pop slot is allocated, so they never collide.
    always_comb begin
        malloc_d = malloc_q;
        cnt_d    = cnt_q;
        if (flush) begin
            malloc_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_acc) malloc_d[free_idx] = 1'b1;
            if (pop_acc)  malloc_d[jal_buffer_pop_index] = 1'b0;
            cnt_d = cnt_q + CW'(push_acc) - CW'(pop_acc);
        end
        full_d = (cnt_d == CW'(DP));
        err_d  = err_q | push_bad | pop_bad;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            malloc_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            malloc_q <= malloc_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            err_q    <= err_d;
        end
    end

    // Payload flops: written only on an accepted push; popped entries keep
    // their stale contents.
    for (genvar g = 0; g < DP; g++) begin : g_entry
        always_ff @(posedge CLK) begin
            if (RST) begin
                info_q[g] <= '0;
            end else if (push_acc && (free_idx == IW'(g))) begin
                info_q[g] <= jal_dispat_info;
            end
        end
        assign jal_issue_info[DW*g +: DW] = info_q[g];
    end

    assign jal_buffer_malloc = malloc_q;
    assign jal_buffer_cnt    = cnt_q;
    assign jal_buffer_full   = full_q;
    assign jal_buffer_err    = err_q;

endmodule
